// File: rtl/cd_irq_csr.sv
// Interrupt register bank for the CDBUS CSR: per-source level/sticky-edge flags,
// mask, selectable clear policy and an event-count / holdoff coalescing FSM.
module cd_irq_csr #(
    parameter int               N_SRC    = 16,
    parameter logic [N_SRC-1:0] MODE_RST = '1,
    parameter int               HOLD_W   = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [N_SRC-1:0] src_in,
    input  logic [4:0]       csr_address,
    input  logic             csr_read,
    output logic [7:0]       csr_readdata,
    input  logic             csr_write,
    input  logic [7:0]       csr_writedata,
    output logic             irq,
    output logic [1:0]       irq_state
);
    localparam int NB = (N_SRC + 7) / 8;
    localparam int PW = NB * 8;
    localparam logic [15:0] HOLD_MSK = 16'((32'd1 << HOLD_W) - 32'd1);

    typedef enum logic [1:0] {IDLE = 2'b00, WAIT = 2'b01, ASSERT = 2'b10} state_t;
    state_t state_q, state_n;

    logic [N_SRC-1:0] src_d, sticky, mask, mode, flag;
    logic [N_SRC-1:0] rise, clr, byte_hit, wr_mask, wr_mode, sticky_n, mode_n;
    logic [PW-1:0]    flag_p, mask_p, mode_p, raw_p, wdata_rep, bank_v;
    logic [1:0]       ctrl;
    logic [7:0]       coal_thr, evt_cnt;
    logic [15:0]      hold;
    logic [HOLD_W-1:0] timer, timer_n;
    logic             pend, new_evt, thr_hit;
    logic             sel_flag, sel_mask, sel_mode;

    // Sticky bits are kept at zero for level-mode sources, so a 0->1 mode change starts clean.
    assign flag      = (mode & sticky) | (~mode & src_d);
    assign rise      = src_in & ~src_d;
    assign pend      = |(flag & mask);
    assign new_evt   = |(rise & mode & mask & ~sticky);
    assign flag_p    = PW'(flag);
    assign mask_p    = PW'(mask);
    assign mode_p    = PW'(mode);
    assign raw_p     = PW'(src_d);
    assign wdata_rep = {NB{csr_writedata}};

    assign sel_flag = (csr_address[4:2] == 3'd0);
    assign sel_mask = (csr_address[4:2] == 3'd1);
    assign sel_mode = (csr_address[4:2] == 3'd2);

    always_comb begin
        for (int b = 0; b < N_SRC; b++) begin
            byte_hit[b] = (csr_address[1:0] == 2'(b / 8));
        end
    end

    assign clr = ctrl[0] ? ({N_SRC{csr_write && sel_flag}} & byte_hit & wdata_rep[N_SRC-1:0])
                         : ({N_SRC{csr_read  && sel_flag}} & byte_hit & flag);
    assign wr_mask  = {N_SRC{csr_write && sel_mask}} & byte_hit;
    assign wr_mode  = {N_SRC{csr_write && sel_mode}} & byte_hit;
    assign mode_n   = (mode & ~wr_mode) | (wdata_rep[N_SRC-1:0] & wr_mode);
    // Set wins over a same-cycle clear.
    assign sticky_n = ((sticky & ~clr) | (rise & mode)) & mode_n;

    always_comb begin
        csr_readdata = 8'h00;
        case (csr_address[4:2])
            3'd0:    bank_v = flag_p;
            3'd1:    bank_v = mask_p;
            3'd2:    bank_v = mode_p;
            3'd3:    bank_v = raw_p;
            default: bank_v = '0;
        endcase
        for (int i = 0; i < NB; i++) begin
            if (csr_address[1:0] == 2'(i)) csr_readdata = bank_v[8*i +: 8];
        end
        case (csr_address)
            5'h10:   csr_readdata = {6'd0, ctrl};
            5'h11:   csr_readdata = coal_thr;
            5'h12:   csr_readdata = hold[7:0];
            5'h13:   csr_readdata = hold[15:8];
            5'h14:   csr_readdata = evt_cnt;
            5'h15:   csr_readdata = {6'd0, state_q};
            default: ;
        endcase
    end

    always_comb begin
        state_n = state_q;
        timer_n = timer;
        thr_hit = (coal_thr != 8'd0) && (evt_cnt >= coal_thr);
        case (state_q)
            IDLE: begin
                if (pend) begin
                    if (ctrl[1]) begin
                        state_n = WAIT;
                        timer_n = hold[HOLD_W-1:0];
                    end else begin
                        state_n = ASSERT;
                    end
                end
            end
            WAIT: begin
                if (!pend)                                    state_n = IDLE;
                else if (!ctrl[1] || thr_hit || timer == '0)  state_n = ASSERT;
                else                                          timer_n = timer - HOLD_W'(1);
            end
            ASSERT: if (!pend) state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            src_d    <= '0;
            sticky   <= '0;
            mask     <= '0;
            mode     <= MODE_RST;
            ctrl     <= 2'b00;
            coal_thr <= 8'h00;
            hold     <= 16'h0000;
            evt_cnt  <= 8'h00;
            timer    <= '0;
            state_q  <= IDLE;
        end else begin
            src_d   <= src_in;
            sticky  <= sticky_n;
            mask    <= (mask & ~wr_mask) | (wdata_rep[N_SRC-1:0] & wr_mask);
            mode    <= mode_n;
            timer   <= timer_n;
            state_q <= state_n;
            // The event that pulls the FSM out of IDLE is deliberately not counted.
            if (state_n == IDLE)
                evt_cnt <= 8'h00;
            else if (state_q != IDLE && new_evt && evt_cnt != 8'hff)
                evt_cnt <= evt_cnt + 8'd1;
            if (csr_write) begin
                case (csr_address)
                    5'h10:   ctrl       <= csr_writedata[1:0];
                    5'h11:   coal_thr   <= csr_writedata;
                    5'h12:   hold[7:0]  <= csr_writedata & HOLD_MSK[7:0];
                    5'h13:   hold[15:8] <= csr_writedata & HOLD_MSK[15:8];
                    default: ;
                endcase
            end
        end
    end

    assign irq       = (state_q == ASSERT);
    assign irq_state = state_q;
endmodule

// File: tb/tb_cd_irq_csr.sv
// Directed bench for cd_irq_csr: flag set/clear policies, coalescing paths and reset.
`timescale 1ns/1ps
module tb_cd_irq_csr;
    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] src_in;
    logic [4:0]  csr_address;
    logic        csr_read;
    logic [7:0]  csr_readdata;
    logic        csr_write;
    logic [7:0]  csr_writedata;
    logic        irq;
    logic [1:0]  irq_state;

    int checks = 0;
    int errors = 0;

    cd_irq_csr #(.N_SRC(16), .MODE_RST(16'hffff), .HOLD_W(16)) dut (
        .clk(clk), .reset(reset), .src_in(src_in),
        .csr_address(csr_address), .csr_read(csr_read), .csr_readdata(csr_readdata),
        .csr_write(csr_write), .csr_writedata(csr_writedata),
        .irq(irq), .irq_state(irq_state)
    );

    always #50 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(negedge clk);
    endtask

    task automatic csr_wr(input logic [4:0] a, input logic [7:0] d);
        csr_address = a; csr_writedata = d; csr_write = 1'b1;
        @(negedge clk);
        csr_write = 1'b0;
    endtask

    task automatic rd(input logic [4:0] a, output logic [7:0] d);
        csr_address = a; csr_read = 1'b1;
        #1 d = csr_readdata;
        @(negedge clk);
        csr_read = 1'b0;
    endtask

    task automatic peek(input logic [4:0] a, output logic [7:0] d);
        csr_address = a; csr_read = 1'b0;
        #1 d = csr_readdata;
    endtask

    task automatic test_reset();
        logic [7:0] d;
        checks++; if (irq !== 1'b0) begin errors++; $display("FAIL rst_irq got %b exp 0", irq); end
        checks++; if (irq_state !== 2'b00) begin errors++; $display("FAIL rst_state got %b exp 00", irq_state); end
        peek(5'h08, d);
        checks++; if (d !== 8'hff) begin errors++; $display("FAIL rst_mode0 got %h exp ff", d); end
        peek(5'h04, d);
        checks++; if (d !== 8'h00) begin errors++; $display("FAIL rst_mask0 got %h exp 00", d); end
        peek(5'h00, d);
        checks++; if (d !== 8'h00) begin errors++; $display("FAIL rst_flag0 got %h exp 00", d); end
    endtask

    task automatic test_r2c();
        logic [7:0] d;
        csr_wr(5'h04, 8'h01);
        src_in = 16'h0001; step();
        peek(5'h00, d);
        checks++; if (d !== 8'h01) begin errors++; $display("FAIL r2c_flag_set got %h exp 01", d); end
        checks++; if (irq !== 1'b0) begin errors++; $display("FAIL r2c_irq_early got %b exp 0", irq); end
        src_in = 16'h0000; step();
        checks++; if (irq !== 1'b1) begin errors++; $display("FAIL r2c_irq_high got %b exp 1", irq); end
        rd(5'h00, d);
        checks++; if (d !== 8'h01) begin errors++; $display("FAIL r2c_read got %h exp 01", d); end
        peek(5'h00, d);
        checks++; if (d !== 8'h00) begin errors++; $display("FAIL r2c_cleared got %h exp 00", d); end
        checks++; if (irq !== 1'b1) begin errors++; $display("FAIL r2c_irq_hold got %b exp 1", irq); end
        step();
        checks++; if (irq !== 1'b0) begin errors++; $display("FAIL r2c_irq_low got %b exp 0", irq); end
    endtask

    task automatic test_w1c();
        logic [7:0] d;
        csr_wr(5'h10, 8'h01);
        src_in = 16'h0208; step();
        src_in = 16'h0000; step();
        peek(5'h00, d);
        checks++; if (d !== 8'h08) begin errors++; $display("FAIL w1c_flag0 got %h exp 08", d); end
        peek(5'h01, d);
        checks++; if (d !== 8'h02) begin errors++; $display("FAIL w1c_flag1 got %h exp 02", d); end
        rd(5'h00, d);
        checks++; if (d !== 8'h08) begin errors++; $display("FAIL w1c_read got %h exp 08", d); end
        peek(5'h00, d);
        checks++; if (d !== 8'h08) begin errors++; $display("FAIL w1c_read_noclr got %h exp 08", d); end
        csr_wr(5'h00, 8'h08);
        peek(5'h00, d);
        checks++; if (d !== 8'h00) begin errors++; $display("FAIL w1c_clr0 got %h exp 00", d); end
        peek(5'h01, d);
        checks++; if (d !== 8'h02) begin errors++; $display("FAIL w1c_keep1 got %h exp 02", d); end
        csr_wr(5'h01, 8'h02);
        peek(5'h01, d);
        checks++; if (d !== 8'h00) begin errors++; $display("FAIL w1c_clr1 got %h exp 00", d); end
        checks++; if (irq !== 1'b0) begin errors++; $display("FAIL w1c_irq got %b exp 0", irq); end
        csr_wr(5'h10, 8'h00);
    endtask

    task automatic test_collision();
        logic [7:0] d;
        src_in = 16'h0004; step();
        src_in = 16'h0000; step();
        csr_address = 5'h00; csr_read = 1'b1; src_in = 16'h0004;
        #1 d = csr_readdata;
        checks++; if (d !== 8'h04) begin errors++; $display("FAIL coll_read got %h exp 04", d); end
        step();
        csr_read = 1'b0; src_in = 16'h0000;
        peek(5'h00, d);
        checks++; if (d !== 8'h04) begin errors++; $display("FAIL coll_set_wins got %h exp 04", d); end
        rd(5'h00, d);
        peek(5'h00, d);
        checks++; if (d !== 8'h00) begin errors++; $display("FAIL coll_later_clr got %h exp 00", d); end
    endtask

    task automatic test_count();
        logic [7:0] d;
        csr_wr(5'h04, 8'hff);
        csr_wr(5'h11, 8'd3);
        csr_wr(5'h12, 8'hff);
        csr_wr(5'h13, 8'hff);
        csr_wr(5'h10, 8'h02);
        src_in = 16'h0001; step();
        src_in = 16'h0000; step();
        peek(5'h15, d);
        checks++; if (d !== 8'h01) begin errors++; $display("FAIL cnt_status_wait got %h exp 01", d); end
        peek(5'h14, d);
        checks++; if (d !== 8'd0) begin errors++; $display("FAIL cnt_first_uncounted got %0d exp 0", d); end
        src_in = 16'h0002; step();
        src_in = 16'h0000; step();
        peek(5'h14, d);
        checks++; if (d !== 8'd1) begin errors++; $display("FAIL cnt_second got %0d exp 1", d); end
        src_in = 16'h0004; step();
        src_in = 16'h0000; step();
        src_in = 16'h0008; step();
        peek(5'h14, d);
        checks++; if (d !== 8'd3) begin errors++; $display("FAIL cnt_fourth got %0d exp 3", d); end
        checks++; if (irq_state !== 2'b01) begin errors++; $display("FAIL cnt_still_wait got %b exp 01", irq_state); end
        src_in = 16'h0000; step();
        checks++; if (irq_state !== 2'b10 || irq !== 1'b1) begin errors++; $display("FAIL cnt_assert got state %b irq %b exp 10 1", irq_state, irq); end
        src_in = 16'h0010; step();
        src_in = 16'h0000;
        peek(5'h14, d);
        checks++; if (d !== 8'd4) begin errors++; $display("FAIL cnt_in_assert got %0d exp 4", d); end
        step();
        rd(5'h00, d);
        checks++; if (d !== 8'h1f) begin errors++; $display("FAIL cnt_flags got %h exp 1f", d); end
        step();
        checks++; if (irq_state !== 2'b00) begin errors++; $display("FAIL cnt_idle got %b exp 00", irq_state); end
        peek(5'h14, d);
        checks++; if (d !== 8'd0) begin errors++; $display("FAIL cnt_reset_idle got %0d exp 0", d); end
    endtask

    task automatic test_holdoff();
        logic [7:0] d;
        int n_wait;
        logic seen;
        csr_wr(5'h11, 8'd0);
        csr_wr(5'h12, 8'd10);
        csr_wr(5'h13, 8'd0);
        src_in = 16'h0020; step();
        src_in = 16'h0000;
        n_wait = 0;
        for (int i = 0; i < 20; i++) begin
            step();
            if (irq_state == 2'b01) n_wait++;
            if (irq_state == 2'b10) break;
        end
        checks++; if (n_wait != 11) begin errors++; $display("FAIL hold_wait_len got %0d exp 11", n_wait); end
        checks++; if (irq !== 1'b1) begin errors++; $display("FAIL hold_irq got %b exp 1", irq); end
        rd(5'h00, d);
        step();
        checks++; if (irq !== 1'b0) begin errors++; $display("FAIL hold_irq_clr got %b exp 0", irq); end
        src_in = 16'h0040; step();
        src_in = 16'h0000; step();
        step(); step();
        checks++; if (irq_state !== 2'b01) begin errors++; $display("FAIL hold2_wait got %b exp 01", irq_state); end
        rd(5'h00, d);
        checks++; if (d !== 8'h40) begin errors++; $display("FAIL hold2_read got %h exp 40", d); end
        seen = 1'b0;
        for (int i = 0; i < 15; i++) begin
            step();
            if (irq) seen = 1'b1;
        end
        checks++; if (seen !== 1'b0) begin errors++; $display("FAIL hold2_no_irq got %b exp 0", seen); end
        checks++; if (irq_state !== 2'b00) begin errors++; $display("FAIL hold2_idle got %b exp 00", irq_state); end
    endtask

    task automatic test_coal_off_mask_drop();
        logic [7:0] d;
        csr_wr(5'h12, 8'hff);
        src_in = 16'h0080; step();
        src_in = 16'h0000; step();
        checks++; if (irq_state !== 2'b01) begin errors++; $display("FAIL coff_wait got %b exp 01", irq_state); end
        csr_wr(5'h10, 8'h00);
        checks++; if (irq_state !== 2'b01) begin errors++; $display("FAIL coff_wait2 got %b exp 01", irq_state); end
        step();
        checks++; if (irq !== 1'b1) begin errors++; $display("FAIL coff_assert got %b exp 1", irq); end
        csr_wr(5'h04, 8'h00);
        checks++; if (irq !== 1'b1) begin errors++; $display("FAIL mdrop_hold got %b exp 1", irq); end
        step();
        checks++; if (irq !== 1'b0 || irq_state !== 2'b00) begin errors++; $display("FAIL mdrop_idle got irq %b state %b exp 0 00", irq, irq_state); end
        rd(5'h00, d);
        checks++; if (d !== 8'h80) begin errors++; $display("FAIL mdrop_flag got %h exp 80", d); end
    endtask

    task automatic test_level_reset();
        logic [7:0] d;
        csr_wr(5'h08, 8'h00);
        csr_wr(5'h04, 8'h02);
        src_in = 16'h0002; step();
        peek(5'h00, d);
        checks++; if (d !== 8'h02) begin errors++; $display("FAIL lvl_flag got %h exp 02", d); end
        step();
        checks++; if (irq !== 1'b1) begin errors++; $display("FAIL lvl_irq got %b exp 1", irq); end
        csr_wr(5'h10, 8'h01);
        csr_wr(5'h00, 8'h02);
        peek(5'h00, d);
        checks++; if (d !== 8'h02 || irq !== 1'b1) begin errors++; $display("FAIL lvl_w1c_ignored got %h irq %b exp 02 1", d, irq); end
        src_in = 16'h0000; step();
        peek(5'h00, d);
        checks++; if (d !== 8'h00) begin errors++; $display("FAIL lvl_follow got %h exp 00", d); end
        step();
        checks++; if (irq !== 1'b0) begin errors++; $display("FAIL lvl_irq_low got %b exp 0", irq); end
        src_in = 16'h0104; step();
        peek(5'h0c, d);
        checks++; if (d !== 8'h04) begin errors++; $display("FAIL raw0 got %h exp 04", d); end
        peek(5'h0d, d);
        checks++; if (d !== 8'h01) begin errors++; $display("FAIL raw1 got %h exp 01", d); end
        src_in = 16'h0000; step();
        csr_wr(5'h08, 8'hff);
        csr_wr(5'h12, 8'hff);
        csr_wr(5'h13, 8'h00);
        csr_wr(5'h04, 8'h01);
        csr_wr(5'h06, 8'hff);
        csr_wr(5'h11, 8'h05);
        csr_wr(5'h10, 8'h02);
        src_in = 16'h0001; step();
        src_in = 16'h0000; step();
        checks++; if (irq_state !== 2'b01) begin errors++; $display("FAIL rst_pre_wait got %b exp 01", irq_state); end
        reset = 1'b1; step();
        reset = 1'b0;
        checks++; if (irq !== 1'b0 || irq_state !== 2'b00) begin errors++; $display("FAIL rst_mid_fsm got irq %b state %b exp 0 00", irq, irq_state); end
        peek(5'h00, d);
        checks++; if (d !== 8'h00) begin errors++; $display("FAIL rst_mid_flag0 got %h exp 00", d); end
        peek(5'h01, d);
        checks++; if (d !== 8'h00) begin errors++; $display("FAIL rst_mid_flag1 got %h exp 00", d); end
        peek(5'h04, d);
        checks++; if (d !== 8'h00) begin errors++; $display("FAIL rst_mid_mask0 got %h exp 00", d); end
        peek(5'h08, d);
        checks++; if (d !== 8'hff) begin errors++; $display("FAIL rst_mid_mode0 got %h exp ff", d); end
        peek(5'h10, d);
        checks++; if (d !== 8'h00) begin errors++; $display("FAIL rst_mid_ctrl got %h exp 00", d); end
        peek(5'h11, d);
        checks++; if (d !== 8'h00) begin errors++; $display("FAIL rst_mid_thr got %h exp 00", d); end
        peek(5'h12, d);
        checks++; if (d !== 8'h00) begin errors++; $display("FAIL rst_mid_hold got %h exp 00", d); end
        peek(5'h06, d);
        checks++; if (d !== 8'h00) begin errors++; $display("FAIL unmapped_byte got %h exp 00", d); end
        peek(5'h1f, d);
        checks++; if (d !== 8'h00) begin errors++; $display("FAIL unmapped_addr got %h exp 00", d); end
    endtask

    initial begin
        reset = 1'b1; src_in = '0; csr_address = '0; csr_read = 1'b0;
        csr_write = 1'b0; csr_writedata = '0;
        repeat (3) step();
        reset = 1'b0;
        step();
        test_reset();
        test_r2c();
        test_w1c();
        test_collision();
        test_count();
        test_holdoff();
        test_coal_off_mask_drop();
        test_level_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
